// File: rtl/sd_cmd_tx_gen.sv
// SD-card CMD line transmitter: serialises a start/transmission header, command index,
// argument, CRC7 and end bit on tick strobes, then holds the line idle for N_CC ticks.
module sd_cmd_tx_gen #(
    parameter int ARG_W      = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [5:0]       cmd_index,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             sd_cmd,
    output logic             busy,
    output logic             done
);
    localparam int SH_W    = ARG_W + 8;
    localparam int CNT_MAX = (SH_W > GAP_CYCLES) ? SH_W : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SH_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CRC   = 3'd2,
        ST_ENDB  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SH_W-1:0]   r_shift;
    logic [SH_W-1:0]   w_shift_nxt;
    logic [6:0]        r_crc;
    logic [6:0]        w_crc_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_sd_cmd;
    logic              w_sd_cmd_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    // CRC7 (x^7 + x^3 + 1) serial update for one message bit.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // State and datapath registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= {SH_W{1'b0}};
            r_crc    <= 7'h00;
            r_cnt    <= CNT_ZERO;
            r_sd_cmd <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_crc    <= w_crc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sd_cmd <= w_sd_cmd_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a tick advances it.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_crc_nxt    = r_crc;
        w_cnt_nxt    = r_cnt;
        w_sd_cmd_nxt = r_sd_cmd;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        if (r_state != ST_IDLE && abort) begin
            // Abort discards the frame without a done pulse, regardless of tick.
            w_state_nxt  = ST_IDLE;
            w_crc_nxt    = 7'h00;
            w_cnt_nxt    = CNT_ZERO;
            w_sd_cmd_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        w_shift_nxt = {1'b0, 1'b1, cmd_index, cmd_arg};
                        w_crc_nxt   = 7'h00;
                        w_cnt_nxt   = CNT_ZERO;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        w_sd_cmd_nxt = r_shift[SH_W-1];
                        w_crc_nxt    = crc7_step(r_crc, r_shift[SH_W-1]);
                        w_shift_nxt  = {r_shift[SH_W-2:0], 1'b0};
                        if (r_cnt == SH_LAST) begin
                            w_cnt_nxt   = CNT_ZERO;
                            w_state_nxt = ST_CRC;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_CRC: begin
                    if (tick) begin
                        w_sd_cmd_nxt = r_crc[6];
                        w_crc_nxt    = {r_crc[5:0], 1'b0};
                        if (r_cnt == CRC_LAST) begin
                            w_cnt_nxt   = CNT_ZERO;
                            w_state_nxt = ST_ENDB;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_CRC;
                    end
                end
                ST_ENDB: begin
                    if (tick) begin
                        w_sd_cmd_nxt = 1'b1;
                        w_cnt_nxt    = CNT_ZERO;
                        if (GAP_CYCLES == 0) begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_state_nxt = ST_ENDB;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        w_sd_cmd_nxt = 1'b1;
                        if (r_cnt == GAP_LAST) begin
                            w_cnt_nxt   = CNT_ZERO;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = CNT_ZERO;
                    w_crc_nxt    = 7'h00;
                    w_sd_cmd_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign sd_cmd = r_sd_cmd;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_sd_cmd_tx_gen.sv
// Randomised self-checking bench for sd_cmd_tx_gen: frames are compared against a
// polynomial-division reference model and against known SD command encodings.
module tb_sd_cmd_tx_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        start;
    logic        start0;
    logic        abort;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        sd_cmd, busy, done;
    logic        sd_cmd0, busy0, done0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sd_cmd_tx_gen #(.ARG_W(32), .GAP_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .sd_cmd(sd_cmd), .busy(busy), .done(done)
    );

    sd_cmd_tx_gen #(.ARG_W(32), .GAP_CYCLES(0)) u_dut_g0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start0), .abort(abort),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .sd_cmd(sd_cmd0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference frame: CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [47:0] exp_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'b0000000};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return {m, r[6:0], 1'b1};
    endfunction

    // Called at a negedge; sends one frame, perturbing inputs while busy.
    task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                             input int period, output logic [47:0] got);
        int   ntick, done_cnt, hold_bad, gap_bad, busy_bad, c;
        logic tk, prev, fin;
        ntick = 0; done_cnt = 0; hold_bad = 0; gap_bad = 0; busy_bad = 0; c = 0;
        fin = 1'b0;
        got = 48'h0;
        tick = 1'($urandom_range(0, 1));
        start = 1'b1; abort = 1'b0; cmd_index = idx; cmd_arg = arg;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", 64'(busy), 64'(1'b1));
        chk("accept_done_low", 64'(done), 64'(1'b0));
        chk("accept_line_idle", 64'(sd_cmd), 64'(1'b1));
        while (!fin && c < 4000) begin
            if (period == 0) tk = ($urandom_range(0, 2) == 0);
            else             tk = ((c % period) == (period - 1));
            tick      = tk;
            start     = (ntick < 40) && ($urandom_range(0, 7) == 0);
            cmd_index = 6'($urandom);
            cmd_arg   = $urandom;
            prev      = sd_cmd;
            @(negedge clk);
            c++;
            if (tk) begin
                ntick++;
                if (ntick <= 48) got[48 - ntick] = sd_cmd;
                else if (sd_cmd !== 1'b1) gap_bad++;
            end else if (sd_cmd !== prev) begin
                hold_bad++;
            end
            if (done === 1'b1) done_cnt++;
            if (tk && ntick == 56) fin = 1'b1;
            else if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        tick  = 1'b0;
        chk("frame_timeout", 64'(fin), 64'(1'b1));
        chk("done_on_last_gap", 64'(done), 64'(1'b1));
        chk("busy_low_at_done", 64'(busy), 64'(1'b0));
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("hold_without_tick", 64'(hold_bad), 64'(0));
        chk("gap_high", 64'(gap_bad), 64'(0));
        chk("busy_during_frame", 64'(busy_bad), 64'(0));
    endtask

    initial begin
        logic [47:0] got;
        logic [47:0] got0;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        int          cnt;

        reset = 1'b0; tick = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0;
        cmd_index = 6'd0; cmd_arg = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_line", 64'(sd_cmd), 64'(1'b1));
        chk("reset_busy", 64'(busy), 64'(1'b0));
        chk("reset_done", 64'(done), 64'(1'b0));
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy !== 1'b0 || sd_cmd !== 1'b1 || done !== 1'b0) cnt++;
        end
        chk("idle_after_reset", 64'(cnt), 64'(0));

        run_frame(6'd0, 32'h0000_0000, 1, got);
        chk("cmd0_frame", 64'(got), 64'(48'h40_0000_0000_95));
        run_frame(6'd8, 32'h0000_01AA, 1, got);
        chk("cmd8_frame", 64'(got), 64'(48'h48_0000_01AA_87));
        run_frame(6'd17, 32'h0000_0000, 1, got);
        chk("cmd17_frame", 64'(got), 64'(48'h51_0000_0000_55));
        run_frame(6'd0, 32'h0000_0000, 4, got);
        chk("cmd0_tick4", 64'(got), 64'(48'h40_0000_0000_95));

        for (int i = 0; i < 6; i++) begin
            ridx = 6'($urandom);
            rarg = $urandom;
            run_frame(ridx, rarg, $urandom_range(0, 4), got);
            chk("random_frame", 64'(got), 64'(exp_frame(ridx, rarg)));
        end

        // Abort and start together in idle: abort wins.
        tick = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", 64'(busy), 64'(1'b0));
        chk("abort_start_idle_line", 64'(sd_cmd), 64'(1'b1));

        // Abort at bit 20, then confirm no done and a clean follow-up frame.
        cmd_index = 6'd8; cmd_arg = 32'h0000_01AA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        tick = 1'($urandom_range(0, 1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_line", 64'(sd_cmd), 64'(1'b1));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        cnt = 0;
        tick = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'(0));
        ridx = 6'($urandom);
        rarg = $urandom;
        run_frame(ridx, rarg, 1, got);
        chk("after_abort_frame", 64'(got), 64'(exp_frame(ridx, rarg)));

        // Reset pulled low mid-CRC, between clock edges.
        tick = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (42) @(negedge clk);
        chk("mid_crc_bit", 64'(sd_cmd), 64'(1'b0));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_line", 64'(sd_cmd), 64'(1'b1));
        chk("async_reset_busy", 64'(busy), 64'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || sd_cmd !== 1'b1) cnt++;
        end
        chk("no_action_after_reset", 64'(cnt), 64'(0));

        // Zero-gap instance: done lands on the end-bit edge.
        ridx = 6'($urandom);
        rarg = $urandom;
        tick = 1'b1; cmd_index = ridx; cmd_arg = rarg; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("g0_accept_busy", 64'(busy0), 64'(1'b1));
        got0 = 48'h0;
        cnt = 0;
        for (int n = 1; n <= 48; n++) begin
            @(negedge clk);
            got0[48 - n] = sd_cmd0;
            if (n < 48 && done0 !== 1'b0) cnt++;
        end
        chk("g0_frame", 64'(got0), 64'(exp_frame(ridx, rarg)));
        chk("g0_early_done", 64'(cnt), 64'(0));
        chk("g0_done_endbit", 64'(done0), 64'(1'b1));
        chk("g0_busy_low", 64'(busy0), 64'(1'b0));
        @(negedge clk);
        chk("g0_done_one_cycle", 64'(done0), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
